pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle program-counter sequencer.
// Steps FETCH -> DECODE -> EXEC -> UPDATE for each instruction, with a HALT
// state that is left on a resume pulse. All outputs come from registers.
module pc_sequencer #(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [7:0]       imem_addr,
    input  logic             imem_ack,
    input  logic [7:0]       imem_data,
    output logic [7:0]       ir,
    input  logic [2:0]       pcsrc,
    input  logic             is_halt,
    input  logic             zero,
    input  logic [7:0]       brzr_pc,
    input  logic [7:0]       brzi_pc,
    input  logic [7:0]       ji_pc,
    input  logic             resume,
    output logic             reg_we,
    output logic [7:0]       pc,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [2:0]       SRC_BRZR = 3'b000;
    localparam logic [2:0]       SRC_BRZI = 3'b100;
    localparam logic [2:0]       SRC_JI   = 3'b101;
    localparam logic [CNT_W-1:0] RET_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RET_MAX  = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [7:0]       pc_q, pc_d;
    logic [7:0]       ir_q, ir_d;
    logic [7:0]       npc_q, npc_d;
    logic [CNT_W-1:0] ret_q, ret_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic             halted_q, halted_d;

    // Next-state and datapath selection; registered outputs follow the next state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        npc_d   = npc_q;
        ret_d   = ret_q;
        unique case (state_q)
            S_FETCH: begin
                // req_q is low only in the first cycle after reset; an ack
                // there does not belong to a request and is dropped.
                if (req_q && imem_ack) begin
                    ir_d    = imem_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = is_halt ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (pcsrc == SRC_BRZR && zero) begin
                    npc_d = brzr_pc;
                end else if (pcsrc == SRC_BRZI && zero) begin
                    npc_d = brzi_pc;
                end else if (pcsrc == SRC_JI) begin
                    npc_d = ji_pc;
                end else begin
                    npc_d = pc_q + 8'd1;
                end
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                pc_d    = npc_q;
                ret_d   = (ret_q == RET_MAX) ? ret_q : ret_q + RET_ONE;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (resume) begin
                    pc_d    = pc_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        req_d    = (state_d == S_FETCH);
        we_d     = (state_d == S_UPDATE);
        halted_d = (state_d == S_HALT);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            npc_q    <= 8'h00;
            ret_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            npc_q    <= npc_d;
            ret_q    <= ret_d;
            req_q    <= req_d;
            we_q     <= we_d;
            halted_q <= halted_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign reg_we    = we_q;
    assign halted    = halted_q;
    assign retired   = ret_q;

endmodule
